// File: rtl/reg_file_pkg.sv
// Core-wide constants shared by the register file, ALU and decoder.
package reg_file_pkg;
   localparam int XLEN = 32;
   localparam int REG_AW = 5;
   localparam int CNT_W = 6;
   localparam logic [REG_AW-1:0] ZERO_REG = '0;
endpackage

// File: rtl/reg_file_sb_popcount.sv
// Combinational popcount of the scoreboard next state; zero latency, no flow control.
module sb_popcount #(
   parameter int N = 32,
   parameter int W = 6
) (
   input  logic [N-1:0] bits_i,
   output logic [W-1:0] count_o
);
   always_comb begin
      count_o = '0;
      for (int i = 0; i < N; i++) begin
         count_o = count_o + W'(bits_i[i]);
      end
   end
endmodule

// File: rtl/reg_file.sv
// Two-read/one-write register file with write-back bypass and a pending-write scoreboard.
// Reads are combinational (zero latency); writes and scoreboard updates land at the clk edge; no backpressure.
module reg_file
   import reg_file_pkg::*;
#(
   parameter int XLEN   = reg_file_pkg::XLEN,
   parameter int NREGS  = 32,
   parameter bit BYPASS = 1'b1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [REG_AW-1:0]          rs1_addr,
   input  logic [REG_AW-1:0]          rs2_addr,
   output logic [XLEN-1:0]            operand_a,
   output logic [XLEN-1:0]            operand_b,
   input  logic                       wb_en,
   input  logic [REG_AW-1:0]          wb_addr,
   input  logic [XLEN-1:0]            wb_data,
   input  logic                       issue_valid,
   input  logic [REG_AW-1:0]          issue_rd,
   output logic                       rs1_busy,
   output logic                       rs2_busy,
   output logic [CNT_W-1:0]           pending_cnt
);
   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [XLEN-1:0]  regs_d [NREGS];
   logic [NREGS-1:0] sb_q;
   logic [NREGS-1:0] sb_d;
   logic [CNT_W-1:0] pending_cnt_q;
   logic [CNT_W-1:0] pending_cnt_d;

   // x0 and indices beyond the implemented array behave as hardwired zero.
   function automatic logic in_range(input logic [REG_AW-1:0] a);
      return (a != ZERO_REG) && (int'(a) < NREGS);
   endfunction

   function automatic logic fwd_hit(input logic [REG_AW-1:0] a);
      return BYPASS && wb_en && (wb_addr == a);
   endfunction

   function automatic logic [XLEN-1:0] read_port(input logic [REG_AW-1:0] a);
      logic [XLEN-1:0] v;
      v = '0;
      if (!reset && in_range(a)) begin
         if (fwd_hit(a)) v = wb_data;
         else            v = regs_q[a[AW-1:0]];
      end
      return v;
   endfunction

   function automatic logic busy_port(input logic [REG_AW-1:0] a);
      return !reset && in_range(a) && sb_q[a[AW-1:0]] && !fwd_hit(a);
   endfunction

   always_comb begin
      operand_a = read_port(rs1_addr);
      operand_b = read_port(rs2_addr);
      rs1_busy  = busy_port(rs1_addr);
      rs2_busy  = busy_port(rs2_addr);
   end

   always_comb begin
      regs_d = regs_q;
      if (wb_en && in_range(wb_addr)) begin
         regs_d[wb_addr[AW-1:0]] = wb_data;
      end
   end

   // Set is applied after clear so a same-cycle issue keeps the newer write pending.
   always_comb begin
      sb_d = sb_q;
      for (int i = 1; i < NREGS; i++) begin
         if (wb_en && (int'(wb_addr) == i))            sb_d[i] = 1'b0;
         if (issue_valid && (int'(issue_rd) == i))     sb_d[i] = 1'b1;
      end
      sb_d[0] = 1'b0;
   end

   sb_popcount #(
      .N (NREGS),
      .W (CNT_W)
   ) u_sb_popcount (
      .bits_i  (sb_d),
      .count_o (pending_cnt_d)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regs_q        <= '{default: '0};
         sb_q          <= '0;
         pending_cnt_q <= '0;
      end else begin
         regs_q        <= regs_d;
         sb_q          <= sb_d;
         pending_cnt_q <= pending_cnt_d;
      end
   end

   assign pending_cnt = pending_cnt_q;
endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: a 32-entry bypassing instance and a 16-entry non-bypassing one share stimulus.
module tb_reg_file;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  rs1_addr = '0, rs2_addr = '0, wb_addr = '0, issue_rd = '0;
   logic        wb_en = 1'b0, issue_valid = 1'b0;
   logic [31:0] wb_data = '0;

   logic [31:0] oa [2];
   logic [31:0] ob [2];
   logic        b1 [2];
   logic        b2 [2];
   logic [5:0]  cnt [2];

   always #5 clk = ~clk;

   reg_file #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) u_byp (
      .clk(clk), .reset(reset), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .operand_a(oa[0]), .operand_b(ob[0]), .wb_en(wb_en), .wb_addr(wb_addr),
      .wb_data(wb_data), .issue_valid(issue_valid), .issue_rd(issue_rd),
      .rs1_busy(b1[0]), .rs2_busy(b2[0]), .pending_cnt(cnt[0]));

   reg_file #(.XLEN(32), .NREGS(16), .BYPASS(1'b0)) u_nob (
      .clk(clk), .reset(reset), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .operand_a(oa[1]), .operand_b(ob[1]), .wb_en(wb_en), .wb_addr(wb_addr),
      .wb_data(wb_data), .issue_valid(issue_valid), .issue_rd(issue_rd),
      .rs1_busy(b1[1]), .rs2_busy(b2[1]), .pending_cnt(cnt[1]));

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        busy1;
      logic        busy2;
      logic [5:0]  cnt;
   } exp_t;

   exp_t exp_q0[$];
   exp_t exp_q1[$];
   int   checks = 0;
   int   errors = 0;

   // Architectural model: a plain array of values and a set of pending destinations per instance.
   logic [31:0] m_reg [2][32];
   bit          m_pend [2][32];

   function automatic int nregs(input int c);
      return (c == 0) ? 32 : 16;
   endfunction

   function automatic bit byp(input int c);
      return c == 0;
   endfunction

   function automatic bit real_reg(input int c, input int a);
      return a != 0 && a < nregs(c);
   endfunction

   function automatic logic [31:0] m_read(input int c, input int a);
      if (reset || !real_reg(c, a)) return 32'h0;
      if (byp(c) && wb_en && int'(wb_addr) == a) return wb_data;
      return m_reg[c][a];
   endfunction

   function automatic logic m_busy(input int c, input int a);
      if (reset || !real_reg(c, a)) return 1'b0;
      if (byp(c) && wb_en && int'(wb_addr) == a) return 1'b0;
      return m_pend[c][a];
   endfunction

   function automatic int m_count(input int c);
      int n = 0;
      for (int i = 0; i < 32; i++) n += int'(m_pend[c][i]);
      return n;
   endfunction

   task automatic model_clear();
      for (int c = 0; c < 2; c++)
         for (int i = 0; i < 32; i++) begin
            m_reg[c][i]  = 32'h0;
            m_pend[c][i] = 1'b0;
         end
   endtask

   // What the coming clock edge does to the architectural state.
   task automatic model_edge();
      for (int c = 0; c < 2; c++) begin
         if (wb_en && real_reg(c, int'(wb_addr))) begin
            m_reg[c][wb_addr]  = wb_data;
            m_pend[c][wb_addr] = 1'b0;
         end
         if (issue_valid && real_reg(c, int'(issue_rd)))
            m_pend[c][issue_rd] = 1'b1;
      end
   endtask

   task automatic push_expect();
      exp_t e;
      for (int c = 0; c < 2; c++) begin
         e.a     = m_read(c, int'(rs1_addr));
         e.b     = m_read(c, int'(rs2_addr));
         e.busy1 = m_busy(c, int'(rs1_addr));
         e.busy2 = m_busy(c, int'(rs2_addr));
         e.cnt   = 6'(m_count(c));
         if (c == 0) exp_q0.push_back(e);
         else        exp_q1.push_back(e);
      end
   endtask

   task automatic drive(input bit rst_v, input bit we, input int wa, input logic [31:0] wd,
                        input bit iv, input int ir, input int r1, input int r2);
      @(posedge clk);
      #1;
      reset       = rst_v;
      wb_en       = we;
      wb_addr     = 5'(wa);
      wb_data     = wd;
      issue_valid = iv;
      issue_rd    = 5'(ir);
      rs1_addr    = 5'(r1);
      rs2_addr    = 5'(r2);
      if (rst_v) model_clear();
      push_expect();
      if (!rst_v) model_edge();
   endtask

   task automatic idle(input int r1, input int r2);
      drive(1'b0, 1'b0, 0, 32'h0, 1'b0, 0, r1, r2);
   endtask

   // Reset arrives between edges while a write-back and an issue are being presented.
   task automatic mid_reset(input int r1, input int r2);
      @(posedge clk);
      #1;
      wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hBAD0_0009;
      issue_valid = 1'b1; issue_rd = 5'd12;
      rs1_addr = 5'(r1); rs2_addr = 5'(r2);
      #2;
      reset = 1'b1;
      model_clear();
      push_expect();
   endtask

   task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] t=%0t act=%h exp=%h", name, c, $time, act, exp);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         for (int c = 0; c < 2; c++) begin
            if ((c == 0 && exp_q0.size() > 0) || (c == 1 && exp_q1.size() > 0)) begin
               e = (c == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
               chk("operand_a", c, oa[c], e.a);
               chk("operand_b", c, ob[c], e.b);
               chk("rs1_busy", c, 32'(b1[c]), 32'(e.busy1));
               chk("rs2_busy", c, 32'(b2[c]), 32'(e.busy2));
               chk("pending_cnt", c, 32'(cnt[c]), 32'(e.cnt));
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog t=%0t act=running exp=finished", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      model_clear();
      drive(1'b1, 1'b0, 0, 32'h0, 1'b0, 0, 9, 5);
      drive(1'b0, 1'b0, 0, 32'h0, 1'b0, 0, 0, 0);

      // write then read back
      drive(1'b0, 1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 0, 0);
      idle(5, 0);

      // x0 is hardwired
      drive(1'b0, 1'b1, 0, 32'h1234, 1'b1, 0, 0, 0);
      idle(0, 0);

      // bypass vs. old value, with x7 still pending
      drive(1'b0, 1'b1, 7, 32'h1111_1111, 1'b1, 7, 0, 7);
      drive(1'b0, 1'b1, 7, 32'hA5A5A5A5, 1'b0, 0, 7, 7);
      idle(7, 7);

      // issue and write-back collide on x3
      drive(1'b0, 1'b0, 0, 32'h0, 1'b1, 3, 3, 0);
      idle(3, 0);
      drive(1'b0, 1'b1, 3, 32'h0000_0333, 1'b1, 3, 3, 0);
      idle(3, 3);
      drive(1'b0, 1'b1, 3, 32'h0000_0334, 1'b0, 0, 0, 0);

      // reset mid-operation
      drive(1'b0, 1'b1, 9, 32'h0000_0099, 1'b1, 1, 0, 0);
      drive(1'b0, 1'b0, 0, 32'h0, 1'b1, 2, 0, 0);
      drive(1'b0, 1'b0, 0, 32'h0, 1'b1, 9, 1, 2);
      idle(9, 1);
      mid_reset(9, 2);
      drive(1'b1, 1'b1, 6, 32'h0000_0066, 1'b0, 0, 9, 1);
      drive(1'b0, 1'b1, 4, 32'h4444_4444, 1'b0, 0, 9, 2);
      idle(4, 9);

      // fill the scoreboard, then drain it
      for (int i = 1; i < 32; i++) drive(1'b0, 1'b0, 0, 32'h0, 1'b1, i, i, i - 1);
      idle(31, 15);
      for (int i = 1; i < 32; i++) drive(1'b0, 1'b1, i, 32'hF000_0000 | 32'(i), 1'b0, 0, i, i);
      idle(31, 15);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         drive(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), $urandom,
               1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      end
      idle(0, 0);

      @(posedge clk);
      @(negedge clk);
      #1;
      if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
         errors++;
         $display("FAIL drain act=%0d/%0d exp=0/0", exp_q0.size(), exp_q1.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
